readout_ctrl: RTL and testbench

READOUT_CTRL -- requirements
Module: readout_ctrl

---
 rtl/readout_ctrl.sv | 126 ++++++++++++
 tb/tb_readout_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_ctrl.sv
// Purpose : dumps DEPTH words of a synchronous capture RAM to a valid/ready transmitter, in address order.
// Latency : start sampled at edge k -> rd_en in cycle k+1, first tx_valid in cycle k+3 (k+1 with header).
// Backpr. : tx_ready low holds the FSM in SEND (or HDR) with tx_data frozen; no words are lost.
// Option  : define READOUT_HEADER_EN to prepend the HEADER word to every dump.
module readout_ctrl #(
    parameter int unsigned        DATA_W = 8,
    parameter int unsigned        ADDR_W = 8,
    parameter int unsigned        DEPTH  = 256,
    parameter logic [DATA_W-1:0]  HEADER = DATA_W'(8'hA5)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    // Address of the final word of a dump; the counter never goes past it.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        FIN  = 3'd4
`ifdef READOUT_HEADER_EN
        ,
        HDR  = 3'd5
`endif
    } state_t;

    state_t state;

    // Single FSM: every output is a register updated together with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a transition below re-asserts them.
            rd_en <= 1'b0;
            done  <= 1'b0;

            case (state)
                IDLE: begin
                    // start is only looked at here, so a request during a dump is dropped.
                    if (start) begin
                        busy <= 1'b1;
`ifdef READOUT_HEADER_EN
                        state    <= HDR;
                        tx_data  <= HEADER;
                        tx_valid <= 1'b1;
`else
                        state    <= READ;
                        rd_en    <= 1'b1;
`endif
                    end
                end

`ifdef READOUT_HEADER_EN
                HDR: begin
                    // Header stays on the bus until the transmitter takes it.
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        rd_en    <= 1'b1;
                        state    <= READ;
                    end
                end
`endif

                READ: begin
                    // RAM registers the word this cycle; it appears on rd_data in WAIT.
                    state <= WAIT;
                end

                WAIT: begin
                    tx_data  <= rd_data;
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end

                SEND: begin
                    // Hold tx_data/tx_valid untouched until accepted.
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (rd_addr == LAST_ADDR) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                            rd_en   <= 1'b1;
                            state   <= READ;
                        end
                    end
                end

                FIN: begin
                    // The only place the address wraps back to zero.
                    rd_addr <= '0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    rd_addr  <= '0;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_readout_ctrl.sv
// Directed bench for readout_ctrl: DEPTH=4 instance plus a DEPTH=1 instance.
// Cycle n is the clock period that ends at edge n; start is sampled at edge 0.
// Outputs are sampled at the falling edge, inputs driven there too.
`timescale 1ns/1ps
module tb_readout_ctrl;

`ifdef READOUT_HEADER_EN
    localparam int OFS     = 1;
    localparam int FIRST_V = 1;
`else
    localparam int OFS     = 0;
    localparam int FIRST_V = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start1;
    logic       tx_ready, tx_ready1;

    logic       rd_en, tx_valid, busy, done;
    logic [7:0] rd_addr, tx_data;
    logic [7:0] rd_data = 8'h00;

    logic       rd_en1, tx_valid1, busy1, done1;
    logic [7:0] rd_addr1, tx_data1;
    logic [7:0] rd_data1 = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_w  [$];
    logic [7:0] exp_w1 [$];

    int rec_words [$];
    int rec_rden  [$];
    int rec_done  [$];
    int rec_first_valid, rec_busy_first, rec_busy_last;
    int rec_hold_viol, rec_cnt22, rec_addr0;

    always #5 clk = ~clk;

    readout_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(4), .HEADER(8'hA5)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    readout_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(1), .HEADER(8'hA5)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .busy(busy1), .done(done1)
    );

    function automatic logic [7:0] ram0_word(input logic [7:0] a);
        case (a)
            8'd0:    return 8'h11;
            8'd1:    return 8'h22;
            8'd2:    return 8'h33;
            8'd3:    return 8'h44;
            default: return 8'h00;
        endcase
    endfunction

    // Synchronous RAM models: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en)  rd_data  <= ram0_word(rd_addr);
        if (rd_en1) rd_data1 <= (rd_addr1 == 8'd0) ? 8'h7E : 8'h00;
    end

    // Drives one dump on the DEPTH=4 instance and records what it observes.
    task automatic run_dump(input int ncyc, input int stall_lo, input int stall_hi, input int restart_cyc);
        logic       prev_stall;
        logic [7:0] prev_dat;
        rec_words.delete();
        rec_rden.delete();
        rec_done.delete();
        rec_first_valid = -1;
        rec_busy_first  = -1;
        rec_busy_last   = -1;
        rec_hold_viol   = 0;
        rec_cnt22       = 0;
        rec_addr0       = -1;
        prev_stall      = 1'b0;
        prev_dat        = 8'h00;
        @(negedge clk);
        start    = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            start    = (n == restart_cyc);
            tx_ready = !(n >= stall_lo && n <= stall_hi);
            #1;
            if (rd_en) begin
                rec_rden.push_back(n);
                if (rec_addr0 < 0) rec_addr0 = int'(rd_addr);
            end
            if (done) rec_done.push_back(n);
            if (busy) begin
                if (rec_busy_first < 0) rec_busy_first = n;
                rec_busy_last = n;
            end
            if (tx_valid && rec_first_valid < 0) rec_first_valid = n;
            if (tx_valid && tx_data == 8'h22) rec_cnt22++;
            if (prev_stall && (!tx_valid || tx_data != prev_dat)) rec_hold_viol++;
            prev_stall = tx_valid && !tx_ready;
            prev_dat   = tx_data;
            if (tx_valid && tx_ready) rec_words.push_back(int'(tx_data));
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; start1 = 1'b0; tx_ready = 1'b1; tx_ready1 = 1'b1;
        #1;
        checks++; if (rd_en !== 1'b0)    begin errors++; $display("FAIL reset_rd_en got %b exp 0", rd_en); end
        checks++; if (rd_addr !== 8'h00) begin errors++; $display("FAIL reset_rd_addr got %h exp 00", rd_addr); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        // start while held in reset must not be acted on
        start = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({rd_en, tx_valid, busy, done} !== 4'b0) begin
            errors++; $display("FAIL reset_hold got %b exp 0000", {rd_en, tx_valid, busy, done});
        end
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b exp 0", busy); end
    endtask

    task automatic test_basic();
        run_dump(24, -1, -1, -1);
        checks++; if (rec_words.size() !== exp_w.size()) begin
            errors++; $display("FAIL basic_word_count got %0d exp %0d", rec_words.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < rec_words.size(); i++) begin
            checks++; if (rec_words[i] !== int'(exp_w[i])) begin
                errors++; $display("FAIL basic_word%0d got %h exp %h", i, rec_words[i], exp_w[i]);
            end
        end
        checks++; if (rec_rden.size() !== 4) begin
            errors++; $display("FAIL basic_rd_en_count got %0d exp 4", rec_rden.size());
        end
        for (int i = 0; i < 4 && i < rec_rden.size(); i++) begin
            checks++; if (rec_rden[i] !== 1 + OFS + 3 * i) begin
                errors++; $display("FAIL basic_rd_en_cycle%0d got %0d exp %0d", i, rec_rden[i], 1 + OFS + 3 * i);
            end
        end
        checks++; if (rec_done.size() !== 1) begin
            errors++; $display("FAIL basic_done_count got %0d exp 1", rec_done.size());
        end else begin
            checks++; if (rec_done[0] !== 13 + OFS) begin
                errors++; $display("FAIL basic_done_cycle got %0d exp %0d", rec_done[0], 13 + OFS);
            end
        end
        checks++; if (rec_busy_first !== 1) begin
            errors++; $display("FAIL basic_busy_first got %0d exp 1", rec_busy_first);
        end
        checks++; if (rec_busy_last !== 13 + OFS) begin
            errors++; $display("FAIL basic_busy_last got %0d exp %0d", rec_busy_last, 13 + OFS);
        end
        checks++; if (rec_first_valid !== FIRST_V) begin
            errors++; $display("FAIL basic_first_valid got %0d exp %0d", rec_first_valid, FIRST_V);
        end
        checks++; if (rec_addr0 !== 0) begin
            errors++; $display("FAIL basic_first_addr got %0d exp 0", rec_addr0);
        end
    endtask

    task automatic test_stall();
        run_dump(30, 6 + OFS, 10 + OFS, -1);
        checks++; if (rec_words.size() !== exp_w.size()) begin
            errors++; $display("FAIL stall_word_count got %0d exp %0d", rec_words.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < rec_words.size(); i++) begin
            checks++; if (rec_words[i] !== int'(exp_w[i])) begin
                errors++; $display("FAIL stall_word%0d got %h exp %h", i, rec_words[i], exp_w[i]);
            end
        end
        checks++; if (rec_cnt22 !== 6) begin
            errors++; $display("FAIL stall_hold_cycles got %0d exp 6", rec_cnt22);
        end
        checks++; if (rec_hold_viol !== 0) begin
            errors++; $display("FAIL stall_data_stable got %0d changes exp 0", rec_hold_viol);
        end
        checks++; if (rec_done.size() !== 1) begin
            errors++; $display("FAIL stall_done_count got %0d exp 1", rec_done.size());
        end else begin
            checks++; if (rec_done[0] !== 18 + OFS) begin
                errors++; $display("FAIL stall_done_cycle got %0d exp %0d", rec_done[0], 18 + OFS);
            end
        end
    endtask

    task automatic test_restart_ignored();
        run_dump(30, -1, -1, 5 + OFS);
        checks++; if (rec_words.size() !== exp_w.size()) begin
            errors++; $display("FAIL restart_word_count got %0d exp %0d", rec_words.size(), exp_w.size());
        end
        checks++; if (rec_done.size() !== 1) begin
            errors++; $display("FAIL restart_done_count got %0d exp 1", rec_done.size());
        end
        checks++; if (rec_rden.size() !== 4) begin
            errors++; $display("FAIL restart_rd_en_count got %0d exp 4", rec_rden.size());
        end
        // a fresh start from IDLE begins at address 0 again
        run_dump(24, -1, -1, -1);
        checks++; if (rec_addr0 !== 0) begin
            errors++; $display("FAIL restart_new_addr got %0d exp 0", rec_addr0);
        end
        checks++; if (rec_words.size() < 1 || rec_words[0] !== int'(exp_w[0])) begin
            errors++; $display("FAIL restart_new_first_word got %0d words exp first %h", rec_words.size(), exp_w[0]);
        end
    endtask

    task automatic test_reset_mid_dump();
        int bad;
        bad = 0;
        @(negedge clk);
        start    = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 9 + OFS; n++) begin
            @(negedge clk);
            start    = 1'b0;
            tx_ready = (n < 9 + OFS);
        end
        #1;
        checks++; if (!(tx_valid === 1'b1 && tx_data === 8'h33)) begin
            errors++; $display("FAIL midrst_in_send got valid=%b data=%h exp valid=1 data=33", tx_valid, tx_data);
        end
        #2 rst = 1'b0;
        #1;
        checks++; if ({rd_en, tx_valid, busy, done} !== 4'b0) begin
            errors++; $display("FAIL midrst_ctrl_zero got %b exp 0000", {rd_en, tx_valid, busy, done});
        end
        checks++; if ({rd_addr, tx_data} !== 16'h0000) begin
            errors++; $display("FAIL midrst_data_zero got addr=%h data=%h exp 00 00", rd_addr, tx_data);
        end
        tx_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || busy || tx_valid) bad++;
        end
        rst = 1'b1;
        #1;
        if (done || busy || tx_valid) bad++;
        @(negedge clk);
        if (done || busy || tx_valid) bad++;
        checks++; if (bad !== 0) begin
            errors++; $display("FAIL midrst_no_done got %0d active samples exp 0", bad);
        end
        run_dump(24, -1, -1, -1);
        checks++; if (rec_addr0 !== 0) begin
            errors++; $display("FAIL midrst_restart_addr got %0d exp 0", rec_addr0);
        end
        checks++; if (rec_words.size() !== exp_w.size() || rec_words[0] !== int'(exp_w[0])) begin
            errors++; $display("FAIL midrst_restart_words got %0d words exp %0d first %h", rec_words.size(), exp_w.size(), exp_w[0]);
        end
    endtask

    task automatic test_depth1();
        int words [$];
        int rden_cyc, done_cyc, done_cnt, busy_last;
        rden_cyc = -1; done_cyc = -1; done_cnt = 0; busy_last = -1;
        @(negedge clk);
        start1    = 1'b1;
        tx_ready1 = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            #1;
            if (rd_en1 && rden_cyc < 0) rden_cyc = n;
            if (done1) begin done_cnt++; done_cyc = n; end
            if (busy1) busy_last = n;
            if (tx_valid1 && tx_ready1) words.push_back(int'(tx_data1));
        end
        checks++; if (words.size() !== exp_w1.size()) begin
            errors++; $display("FAIL depth1_word_count got %0d exp %0d", words.size(), exp_w1.size());
        end
        for (int i = 0; i < exp_w1.size() && i < words.size(); i++) begin
            checks++; if (words[i] !== int'(exp_w1[i])) begin
                errors++; $display("FAIL depth1_word%0d got %h exp %h", i, words[i], exp_w1[i]);
            end
        end
        checks++; if (rden_cyc !== 1 + OFS) begin
            errors++; $display("FAIL depth1_rd_en_cycle got %0d exp %0d", rden_cyc, 1 + OFS);
        end
        checks++; if (done_cnt !== 1 || done_cyc !== 4 + OFS) begin
            errors++; $display("FAIL depth1_done got count=%0d cycle=%0d exp 1 at %0d", done_cnt, done_cyc, 4 + OFS);
        end
        checks++; if (busy_last !== 4 + OFS || busy1 !== 1'b0) begin
            errors++; $display("FAIL depth1_idle got busy_last=%0d busy=%b exp %0d and 0", busy_last, busy1, 4 + OFS);
        end
    endtask

    initial begin
`ifdef READOUT_HEADER_EN
        exp_w.push_back(8'hA5);
        exp_w1.push_back(8'hA5);
`endif
        exp_w.push_back(8'h11);
        exp_w.push_back(8'h22);
        exp_w.push_back(8'h33);
        exp_w.push_back(8'h44);
        exp_w1.push_back(8'h7E);

        test_reset();
        test_basic();
        test_stall();
        test_restart_ignored();
        test_reset_mid_dump();
        test_depth1();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
